// File: rtl/muldiv_sequencer.sv
// Multi-cycle M-extension controller: radix-2 shift-add multiply and restoring divide,
// 32 iterations, RISC-V sign and special-case rules, with pipeline stall.
module muldiv_sequencer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] operand_a_i,
    input  logic [DATA_W-1:0] operand_b_i,
    input  logic              flush_i,
    output logic              busy_o,
    output logic              stall_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o
);

    localparam int unsigned       PROD_W = 2 * DATA_W;
    localparam logic [DATA_W-1:0] SMIN   = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              sa_q, sa_d;
    logic              sb_q, sb_d;
    logic [DATA_W-1:0] opnd_q, opnd_d;     // multiplicand (MUL*) or divisor (DIV*) magnitude
    logic [DATA_W:0]   hi_q, hi_d;         // product high half / partial remainder
    logic [DATA_W-1:0] lo_q, lo_d;         // multiplier bits / dividend shifting into quotient
    logic [DATA_W-1:0] result_q, result_d;

    logic              accept;
    logic              is_div;
    logic              a_signed;
    logic              b_signed;
    logic              neg_a;
    logic              neg_b;
    logic              div_zero;
    logic              div_ovf;
    logic              special;
    logic [DATA_W-1:0] mag_a;
    logic [DATA_W-1:0] mag_b;
    logic [DATA_W-1:0] special_res;

    // Accept-time decode: operand signedness, magnitudes and the short-circuit cases
    always_comb begin
        accept   = (state_q == S_IDLE) & start_i & ~flush_i;
        is_div   = op_i[2];
        a_signed = is_div ? ~op_i[0] : ((op_i[1:0] == 2'b01) | (op_i[1:0] == 2'b10));
        b_signed = is_div ? ~op_i[0] : (op_i[1:0] == 2'b01);
        neg_a    = a_signed & operand_a_i[DATA_W-1];
        neg_b    = b_signed & operand_b_i[DATA_W-1];
        mag_a    = neg_a ? -operand_a_i : operand_a_i;
        mag_b    = neg_b ? -operand_b_i : operand_b_i;
        div_zero = is_div & (operand_b_i == '0);
        div_ovf  = is_div & ~op_i[0] & (operand_a_i == SMIN) & (operand_b_i == '1);
        special  = div_zero | div_ovf;
        if (div_zero) begin
            special_res = op_i[1] ? operand_a_i : '1;
        end else begin
            special_res = op_i[1] ? '0 : SMIN;
        end
    end

    logic [DATA_W:0]   mul_sum;
    logic [DATA_W:0]   div_shift;
    logic [DATA_W:0]   div_sub;
    logic              div_ge;
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] prod_fix;
    logic [DATA_W-1:0] quot_fix;
    logic [DATA_W-1:0] rem_fix;
    logic [DATA_W-1:0] fix_res;

    // One iteration of each engine, plus the sign fix-up and result select
    always_comb begin
        mul_sum   = hi_q + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {hi_q[DATA_W-1:0], lo_q[DATA_W-1]};
        div_ge    = div_shift >= {1'b0, opnd_q};
        div_sub   = div_shift - {1'b0, opnd_q};
        prod      = {hi_q[DATA_W-1:0], lo_q};
        prod_fix  = (sa_q ^ sb_q) ? -prod : prod;
        quot_fix  = (sa_q ^ sb_q) ? -lo_q : lo_q;
        rem_fix   = sa_q ? -hi_q[DATA_W-1:0] : hi_q[DATA_W-1:0];
        case (op_q)
            3'b000:                 fix_res = prod_fix[DATA_W-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_fix[PROD_W-1:DATA_W];
            3'b100, 3'b101:         fix_res = quot_fix;
            default:                fix_res = rem_fix;
        endcase
    end

    // Datapath next-state
    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d  = op_i;
                    sa_d  = neg_a;
                    sb_d  = neg_b;
                    cnt_d = CNT_W'(DATA_W - 1);
                    hi_d  = '0;
                    if (is_div) begin
                        opnd_d = mag_b;
                        lo_d   = mag_a;
                    end else begin
                        opnd_d = mag_a;
                        lo_d   = mag_b;
                    end
                    if (special) begin
                        result_d = special_res;
                    end
                end
            end
            S_CALC: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (op_q[2]) begin
                    hi_d = div_ge ? div_sub : div_shift;
                    lo_d = {lo_q[DATA_W-2:0], div_ge};
                end else begin
                    hi_d = {1'b0, mul_sum[DATA_W:1]};
                    lo_d = {mul_sum[0], lo_q[DATA_W-1:1]};
                end
            end
            S_FIX: begin
                if (!flush_i) begin
                    result_d = fix_res;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            op_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; flush always returns to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_FIX;
                end
            end
            S_FIX:   state_d = flush_i ? S_IDLE : S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs; stall drops in DONE so the instruction leaves EX that cycle
    always_comb begin
        busy_o   = (state_q != S_IDLE);
        done_o   = (state_q == S_DONE);
        stall_o  = accept | (state_q == S_CALC) | (state_q == S_FIX);
        result_o = result_q;
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench for muldiv_sequencer against a plain-arithmetic
// RISC-V M-extension reference model, plus directed special/flush/reset cases.
`timescale 1ns/1ps
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start_i = 1'b0;
    logic [2:0]  op_i = 3'd0;
    logic [31:0] operand_a_i = 32'd0;
    logic [31:0] operand_b_i = 32'd0;
    logic        flush_i = 1'b0;
    logic        busy_o;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_exp = 32'd0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.DATA_W(32), .CNT_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .op_i        (op_i),
        .operand_a_i (operand_a_i),
        .operand_b_i (operand_b_i),
        .flush_i     (flush_i),
        .busy_o      (busy_o),
        .stall_o     (stall_o),
        .done_o      (done_o),
        .result_o    (result_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // RISC-V M-extension semantics in 64-bit arithmetic
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] ps;
        logic [63:0]        pu;
        int                 ia;
        int                 ib;
        logic               ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ia  = a;
        ib  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        pu  = {32'd0, a} * {32'd0, b};
        case (op)
            3'd0: return pu[31:0];
            3'd1: begin ps = sa * sb; return ps[63:32]; end
            3'd2: begin ps = sa * $signed({32'd0, b}); return ps[63:32]; end
            3'd3: return pu[63:32];
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (ovf) return 32'd0;
                return 32'(ia % ib);
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge of the first IDLE cycle after done.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        logic [31:0] exp;
        int          exp_lat;
        int          lat;
        int          stall_bad;
        bit          got;
        exp     = model(op, a, b);
        exp_lat = (op[2] && (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
                  ? 1 : 34;
        start_i     = 1'b1;
        op_i        = op;
        operand_a_i = a;
        operand_b_i = b;
        #1;
        check({tag, "/stall_at_accept"}, {31'd0, stall_o}, 32'd1);
        check({tag, "/busy_at_accept"}, {31'd0, busy_o}, 32'd0);
        lat       = 0;
        stall_bad = 0;
        got       = 1'b0;
        while (!got && lat < 64) begin
            @(negedge clk);
            lat++;
            if (done_o) begin
                got = 1'b1;
                if (stall_o) stall_bad++;
            end else if (!stall_o || !busy_o) begin
                stall_bad++;
            end
            // Inputs after accept must not matter; no start once done is seen
            start_i     = got ? 1'b0 : 1'($urandom_range(0, 1));
            op_i        = 3'($urandom);
            operand_a_i = $urandom;
            operand_b_i = $urandom;
        end
        check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "/result"}, result_o, exp);
        check({tag, "/stall_profile"}, 32'(stall_bad), 32'd0);
        @(negedge clk);
        check({tag, "/done_one_cycle"}, {31'd0, done_o}, 32'd0);
        check({tag, "/idle_after"}, {31'd0, busy_o}, 32'd0);
        check({tag, "/result_hold"}, result_o, exp);
        last_exp = exp;
    endtask

    initial begin
        int done_seen;

        #1 rst_n = 1'b0;
        #2;
        check("reset/busy", {31'd0, busy_o}, 32'd0);
        check("reset/done", {31'd0, done_o}, 32'd0);
        check("reset/stall", {31'd0, stall_o}, 32'd0);
        check("reset/result", result_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul_7_m3");
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh_min_min");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, "mulhsu_m1_2");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
        run_op(3'd5, 32'd100, 32'd7, "divu_100_7");
        run_op(3'd7, 32'd100, 32'd7, "remu_100_7");
        run_op(3'd5, 32'd5, 32'd0, "divu_by0");
        run_op(3'd6, 32'd5, 32'd0, "rem_by0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");

        // Flush mid-divide at T+10
        start_i     = 1'b1;
        op_i        = 3'd4;
        operand_a_i = 32'd1000;
        operand_b_i = 32'd3;
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("flush/busy", {31'd0, busy_o}, 32'd0);
        check("flush/done", {31'd0, done_o}, 32'd0);
        check("flush/result", result_o, last_exp);
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_o) done_seen++;
        end
        check("flush/no_done", 32'(done_seen), 32'd0);
        check("flush/result_kept", result_o, last_exp);

        // Start with simultaneous flush is not accepted
        start_i = 1'b1;
        flush_i = 1'b1;
        #1;
        check("start_flush/stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        start_i = 1'b0;
        flush_i = 1'b0;
        check("start_flush/busy", {31'd0, busy_o}, 32'd0);

        // Asynchronous reset in the middle of a multiply
        start_i     = 1'b1;
        op_i        = 3'd0;
        operand_a_i = 32'd123;
        operand_b_i = 32'd456;
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst/busy", {31'd0, busy_o}, 32'd0);
        check("midrst/done", {31'd0, done_o}, 32'd0);
        check("midrst/result", result_o, 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        last_exp = 32'd0;
        run_op(3'd0, 32'd3, 32'd4, "mul_3_4_after_rst");

        // Randomized back-to-back operations
        for (int i = 0; i < 150; i++) begin
            logic [2:0]  rop;
            logic [31:0] ra;
            logic [31:0] rb;
            rop = 3'($urandom_range(0, 7));
            ra  = pick_operand();
            rb  = pick_operand();
            run_op(rop, ra, rb, $sformatf("rand%0d_op%0d", i, rop));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
